video_isa_regs: RTL and testbench
=================================

Name: video_isa_regs

Overview:
- Parametrised ISA-side register and bus-timing block for CGA/Tandy-class video adapters.
- Sits between the ISA bus and the CRTC/sequencer/pixel pipeline.
- Synchronises bus strobes and decodes the adapter I/O window.
- Holds mode/color/Tandy gate-array registers (configurable palette depth and width), generates the blink clock, and inserts sequencer-aligned memory wait states.

Parameters:
IO_BASE_ADDR, 16'h3D0, I/O window base (3D0 CGA, 3B0 MDA); bits [14:3] compared
USE_BUS_WAIT, 1, 1 enables wait-state FSM; 0 ties bus_rdy high
SEQ_WIDTH, 5, width of sequencer phase input
WAIT_ENTER, 17, clk_seq value that opens the access slot
WAIT_EXIT, 20, clk_seq value that closes the slot and releases bus_rdy
NUM_PAL, 16, palette entries (1..16)
PAL_WIDTH, 4, bits per palette entry (1..8)
BLINK_WIDTH, 24, blink counter width
BLINK_MAX, 0, blink half-period minus 1

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
bus_a  in  15  ISA address
bus_ior_l/bus_iow_l/bus_memr_l/bus_memw_l  in  1 each  ISA strobes, async, active-low
bus_aen  in  1  DMA address enable; high blocks I/O decode
bus_mem_cs  in  1  framebuffer window hit (decoded upstream)
bus_d  in  8  write data
bus_out  out  8  read data
bus_dir  out  1  high = adapter drives bus
bus_rdy  out  1  ISA ready
clk_seq  in  SEQ_WIDTH  sequencer phase
vsync_l, display_enable  in  1 each  CRTC status inputs
crtc_rdata  in  8  CRTC register read data
crtc_cs, crtc_wr, crtc_rd  out  1 each  CRTC select, synced write level, synced read level
control_reg, color_reg  out  8 each  mode control (base+8), color select (base+9)
border_col  out  4  Tandy border color
pal_flat  out  NUM_PAL*PAL_WIDTH  palette; entry i at [i*PAL_WIDTH +: PAL_WIDTH]
pal_set  out  1  one-cycle pulse on palette write
pal_idx  out  4  index of last written entry
blink  out  1  blink square wave
blink_freeze  in  1  holds the blink counter (splash screen)

Behaviour:
- Reset values: control_reg=8'h29, color_reg=0, border_col=0, pal_flat=0, tandy index=0, pal_set=0, pal_idx=0, blink=0, blink counter=0, bus_rdy=1, wait FSM IDLE, all synced strobes=1 (idle).
- Reset applied mid-operation aborts any wait; bus_rdy=1 on the next cycle.
- Sync: two flops per strobe. crtc_wr=~iow_s2 and crtc_rd=~ior_s2 (level).
- Write pulse wp: iow_s2 falls (prev 1, now 0). Exactly one register update per bus cycle, 3 clk after the falling edge.
- Decode (requires ~bus_aen): crtc_cs when bus_a[14:3]==BASE[14:3]. Control = base+8, color = base+9, status/index = base+A, Tandy data = base+E.
- On wp:
  - control -> control_reg=bus_d.
  - color -> color_reg=bus_d.
  - base+A -> index=bus_d[4:0].
  - base+E, index==5'h02 -> border_col=bus_d[3:0].
  - base+E, index 5'h10+i with i<NUM_PAL -> entry i = bus_d[PAL_WIDTH-1:0]; pal_set=1 for one cycle; pal_idx=i.
  - Other indices, or i>=NUM_PAL: ignored, no pulse.
- Read mux (combinational, raw bus_ior_l):
  - status -> {4'hF, vsync_l, 2'b10, ~display_enable}.
  - crtc_cs & bus_a[0] -> crtc_rdata.
  - Otherwise 8'h00.
  - bus_dir = (crtc_cs|status_cs) & ~bus_ior_l.
- Wait FSM (USE_BUS_WAIT=1). Let req = bus_mem_cs & (~memr_s2 | ~memw_s2).
  - IDLE: req -> WAIT_SLOT, bus_rdy=0.
  - WAIT_SLOT: clk_seq==WAIT_ENTER -> WAIT_END.
  - WAIT_END: clk_seq==WAIT_EXIT -> DONE.
  - DONE: bus_rdy=1 and held until req drops -> IDLE.
  - req drops in any state -> IDLE, bus_rdy=1 next cycle.
  - bus_rdy registered. Maximum low time is two sequencer periods.
- Blink: if blink_freeze, hold. Else if counter==BLINK_MAX, counter=0 and toggle blink. Else counter+1, wrapping modulo 2^BLINK_WIDTH.
- Reset wins over a simultaneous wp. A wp to control and a blink toggle in the same cycle are independent.

Decomposition:
- Package video_pkg: register offsets (OFS_CTRL=8, OFS_COLOR=9, OFS_STATUS=4'hA, OFS_TDATA=4'hE), Tandy indices (TIDX_BORDER=5'h02, TIDX_PAL_BASE=5'h10), wait-state enum (IDLE, WAIT_SLOT, WAIT_END, DONE), CTRL_RESET=8'h29.
- One sub-module: video_bus_wait (wait-state FSM), so it can be reused by the MDA variant.

Test Plan:
- Reset, then write 8'h1A to 3D8 (iow low 6 clk) -> control_reg==8'h1A exactly 3 clk after the iow fall; holding iow low for 20 clk still yields a single update.
- Write 3DA=8'h13 then 3DE=8'h07 -> entry 3 ==4'h7, pal_set pulses 1 cycle, pal_idx==3. With NUM_PAL=4, index 5'h14 write -> no change, no pulse.
- Write 3DA=8'h02, 3DE=8'h0C -> border_col==4'hC; pal_flat unchanged.
- Read 3DA with vsync_l=0, display_enable=1 -> bus_out==8'hF4, bus_dir=1. Read 3D5 with crtc_rdata=8'h55 -> 8'h55. Read 3D4 -> 8'h00, bus_dir=1. Same read with bus_aen=1 -> bus_dir=0.
- Memr with bus_mem_cs, clk_seq counting 0..31 -> bus_rdy low from req+1 until the cycle after clk_seq==20 following a 17. Dropping memr mid-wait -> bus_rdy=1 next cycle. Reset asserted during WAIT_END -> bus_rdy=1, FSM IDLE.
- BLINK_MAX=3 -> blink toggles every 4 clk. blink_freeze high for 10 clk -> no toggle, counter resumes from its held value.

Source files
------------

// File: rtl/video_pkg.sv
// Shared constants and types for the CGA/Tandy ISA register block and its
// wait-state sequencer.
package video_pkg;

    localparam logic [3:0] OFS_CTRL   = 4'h8;
    localparam logic [3:0] OFS_COLOR  = 4'h9;
    localparam logic [3:0] OFS_STATUS = 4'hA;
    localparam logic [3:0] OFS_TDATA  = 4'hE;

    localparam logic [4:0] TIDX_BORDER   = 5'h02;
    localparam logic [4:0] TIDX_PAL_BASE = 5'h10;

    localparam logic [7:0] CTRL_RESET = 8'h29;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SLOT = 2'd1,
        WAIT_END  = 2'd2,
        DONE      = 2'd3
    } wait_state_t;

endpackage

// File: rtl/video_isa_regs_if.sv
// ISA bus signal bundle seen by the video adapter; the host side is the master.
interface video_isa_regs_if;
    logic [14:0] bus_a;
    logic        bus_ior_l;
    logic        bus_iow_l;
    logic        bus_memr_l;
    logic        bus_memw_l;
    logic        bus_aen;
    logic        bus_mem_cs;
    logic [7:0]  bus_d;
    logic [7:0]  bus_out;
    logic        bus_dir;
    logic        bus_rdy;

    modport master (
        output bus_a, bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l,
        output bus_aen, bus_mem_cs, bus_d,
        input  bus_out, bus_dir, bus_rdy
    );

    modport slave (
        input  bus_a, bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l,
        input  bus_aen, bus_mem_cs, bus_d,
        output bus_out, bus_dir, bus_rdy
    );
endinterface

// File: rtl/video_bus_wait.sv
// Holds ISA ready low on framebuffer accesses until the sequencer has passed
// through its CPU access slot; shared with the MDA variant.
module video_bus_wait
    import video_pkg::*;
#(
    parameter int SEQ_WIDTH  = 5,
    parameter int WAIT_ENTER = 17,
    parameter int WAIT_EXIT  = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic [SEQ_WIDTH-1:0] clk_seq,
    output logic                 bus_rdy
);

    wait_state_t state_q, state_d;
    logic        rdy_q, rdy_d;

    // Next-state and next-ready; a dropped request always returns to IDLE.
    always_comb begin
        state_d = state_q;
        rdy_d   = rdy_q;
        if (!req) begin
            state_d = IDLE;
            rdy_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT_SLOT;
                    rdy_d   = 1'b0;
                end
                WAIT_SLOT: begin
                    if (clk_seq == SEQ_WIDTH'(WAIT_ENTER)) begin
                        state_d = WAIT_END;
                    end else begin
                        state_d = WAIT_SLOT;
                    end
                end
                WAIT_END: begin
                    if (clk_seq == SEQ_WIDTH'(WAIT_EXIT)) begin
                        state_d = DONE;
                        rdy_d   = 1'b1;
                    end else begin
                        state_d = WAIT_END;
                    end
                end
                DONE: begin
                    rdy_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    rdy_d   = 1'b1;
                end
            endcase
        end
    end

    // State and ready flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus_rdy = rdy_q;

endmodule

// File: rtl/video_isa_regs.sv
// ISA-side register file, strobe synchroniser, read mux and blink generator
// for CGA/Tandy-class video adapters.
module video_isa_regs
    import video_pkg::*;
#(
    parameter logic [15:0] IO_BASE_ADDR = 16'h3D0,
    parameter bit          USE_BUS_WAIT = 1'b1,
    parameter int          SEQ_WIDTH    = 5,
    parameter int          WAIT_ENTER   = 17,
    parameter int          WAIT_EXIT    = 20,
    parameter int          NUM_PAL      = 16,
    parameter int          PAL_WIDTH    = 4,
    parameter int          BLINK_WIDTH  = 24,
    parameter int          BLINK_MAX    = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    video_isa_regs_if.slave                bus,
    input  logic [SEQ_WIDTH-1:0]           clk_seq,
    input  logic                           vsync_l,
    input  logic                           display_enable,
    input  logic [7:0]                     crtc_rdata,
    output logic                           crtc_cs,
    output logic                           crtc_wr,
    output logic                           crtc_rd,
    output logic [7:0]                     control_reg,
    output logic [7:0]                     color_reg,
    output logic [3:0]                     border_col,
    output logic [NUM_PAL*PAL_WIDTH-1:0]   pal_flat,
    output logic                           pal_set,
    output logic [3:0]                     pal_idx,
    output logic                           blink,
    input  logic                           blink_freeze
);

    logic ior_meta_q, ior_sync_q;
    logic iow_meta_q, iow_sync_q, iow_prev_q;
    logic memr_meta_q, memr_sync_q;
    logic memw_meta_q, memw_sync_q;

    logic [7:0]           ctrl_q, ctrl_d;
    logic [7:0]           color_q, color_d;
    logic [3:0]           border_q, border_d;
    logic [4:0]           tidx_q, tidx_d;
    logic [PAL_WIDTH-1:0] pal_q [NUM_PAL];
    logic [PAL_WIDTH-1:0] pal_d [NUM_PAL];
    logic                 pal_set_q, pal_set_d;
    logic [3:0]           pal_idx_q, pal_idx_d;
    logic [BLINK_WIDTH-1:0] blink_cnt_q, blink_cnt_d;
    logic                 blink_q, blink_d;

    logic       wp_s, hi_cs_s, status_cs_s, pal_hit_s, req_s;
    logic [7:0] rdata_s;

    // Two-flop strobe synchronisers; iow keeps one extra stage for edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            ior_meta_q  <= 1'b1;
            ior_sync_q  <= 1'b1;
            iow_meta_q  <= 1'b1;
            iow_sync_q  <= 1'b1;
            iow_prev_q  <= 1'b1;
            memr_meta_q <= 1'b1;
            memr_sync_q <= 1'b1;
            memw_meta_q <= 1'b1;
            memw_sync_q <= 1'b1;
        end else begin
            ior_meta_q  <= bus.bus_ior_l;
            ior_sync_q  <= ior_meta_q;
            iow_meta_q  <= bus.bus_iow_l;
            iow_sync_q  <= iow_meta_q;
            iow_prev_q  <= iow_sync_q;
            memr_meta_q <= bus.bus_memr_l;
            memr_sync_q <= memr_meta_q;
            memw_meta_q <= bus.bus_memw_l;
            memw_sync_q <= memw_meta_q;
        end
    end

    // The register bank is base+8..base+F; the base is assumed 16-byte aligned.
    assign wp_s        = iow_prev_q & ~iow_sync_q;
    assign crtc_cs     = ~bus.bus_aen & (bus.bus_a[14:3] == IO_BASE_ADDR[14:3]);
    assign hi_cs_s     = ~bus.bus_aen & (bus.bus_a[14:4] == IO_BASE_ADDR[14:4]) & bus.bus_a[3];
    assign status_cs_s = hi_cs_s & (bus.bus_a[3:0] == OFS_STATUS);
    assign pal_hit_s   = ((tidx_q & 5'h10) == TIDX_PAL_BASE) && (int'(tidx_q[3:0]) < NUM_PAL);

    // Register write decode, one update per synchronised iow falling edge.
    always_comb begin
        ctrl_d    = ctrl_q;
        color_d   = color_q;
        border_d  = border_q;
        tidx_d    = tidx_q;
        pal_d     = pal_q;
        pal_set_d = 1'b0;
        pal_idx_d = pal_idx_q;
        if (wp_s && hi_cs_s) begin
            case (bus.bus_a[3:0])
                OFS_CTRL:   ctrl_d  = bus.bus_d;
                OFS_COLOR:  color_d = bus.bus_d;
                OFS_STATUS: tidx_d  = bus.bus_d[4:0];
                OFS_TDATA: begin
                    if (tidx_q == TIDX_BORDER) begin
                        border_d = bus.bus_d[3:0];
                    end else if (pal_hit_s) begin
                        for (int i = 0; i < NUM_PAL; i++) begin
                            if (tidx_q[3:0] == 4'(i)) begin
                                pal_d[i] = bus.bus_d[PAL_WIDTH-1:0];
                            end else begin
                                pal_d[i] = pal_q[i];
                            end
                        end
                        pal_set_d = 1'b1;
                        pal_idx_d = tidx_q[3:0];
                    end else begin
                        pal_set_d = 1'b0;
                    end
                end
                default: ctrl_d = ctrl_q;
            endcase
        end else begin
            pal_set_d = 1'b0;
        end
    end

    // Blink divider; freeze holds both the count and the output phase.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (blink_freeze) begin
            blink_cnt_d = blink_cnt_q;
        end else if (blink_cnt_q == BLINK_WIDTH'(BLINK_MAX)) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLINK_WIDTH'(1);
        end
    end

    // Register bank and blink state.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q      <= CTRL_RESET;
            color_q     <= 8'h00;
            border_q    <= 4'h0;
            tidx_q      <= 5'h00;
            pal_set_q   <= 1'b0;
            pal_idx_q   <= 4'h0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            for (int i = 0; i < NUM_PAL; i++) pal_q[i] <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            color_q     <= color_d;
            border_q    <= border_d;
            tidx_q      <= tidx_d;
            pal_set_q   <= pal_set_d;
            pal_idx_q   <= pal_idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            pal_q       <= pal_d;
        end
    end

    // Palette flattening and read-data mux driven by the raw ior strobe.
    always_comb begin
        pal_flat = '0;
        for (int i = 0; i < NUM_PAL; i++) begin
            pal_flat[i*PAL_WIDTH +: PAL_WIDTH] = pal_q[i];
        end
        rdata_s = 8'h00;
        if (!bus.bus_ior_l && status_cs_s) begin
            rdata_s = {4'hF, vsync_l, 2'b10, ~display_enable};
        end else if (!bus.bus_ior_l && crtc_cs && bus.bus_a[0]) begin
            rdata_s = crtc_rdata;
        end else begin
            rdata_s = 8'h00;
        end
    end

    assign req_s = bus.bus_mem_cs & (~memr_sync_q | ~memw_sync_q);

    generate
        if (USE_BUS_WAIT) begin : gen_wait
            video_bus_wait #(
                .SEQ_WIDTH  (SEQ_WIDTH),
                .WAIT_ENTER (WAIT_ENTER),
                .WAIT_EXIT  (WAIT_EXIT)
            ) u_wait (
                .clk     (clk),
                .reset   (reset),
                .req     (req_s),
                .clk_seq (clk_seq),
                .bus_rdy (bus.bus_rdy)
            );
        end else begin : gen_no_wait
            assign bus.bus_rdy = 1'b1;
        end
    endgenerate

    assign bus.bus_out  = rdata_s;
    assign bus.bus_dir  = (crtc_cs | status_cs_s) & ~bus.bus_ior_l;
    assign crtc_wr      = ~iow_sync_q;
    assign crtc_rd      = ~ior_sync_q;
    assign control_reg  = ctrl_q;
    assign color_reg    = color_q;
    assign border_col   = border_q;
    assign pal_set      = pal_set_q;
    assign pal_idx      = pal_idx_q;
    assign blink        = blink_q;

endmodule

// File: tb/tb_video_isa_regs.sv
// Directed bench for video_isa_regs with a 4-entry palette and a 4-clock blink.
module tb_video_isa_regs;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] clk_seq;
    logic       vsync_l, display_enable, blink_freeze;
    logic [7:0] crtc_rdata;
    logic       crtc_cs, crtc_wr, crtc_rd, pal_set, blink;
    logic [7:0] control_reg, color_reg;
    logic [3:0] border_col, pal_idx;
    logic [15:0] pal_flat;

    int tests  = 0;
    int failed = 0;

    video_isa_regs_if bus ();

    video_isa_regs #(
        .NUM_PAL   (4),
        .PAL_WIDTH (4),
        .BLINK_MAX (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .clk_seq        (clk_seq),
        .vsync_l        (vsync_l),
        .display_enable (display_enable),
        .crtc_rdata     (crtc_rdata),
        .crtc_cs        (crtc_cs),
        .crtc_wr        (crtc_wr),
        .crtc_rd        (crtc_rd),
        .control_reg    (control_reg),
        .color_reg      (color_reg),
        .border_col     (border_col),
        .pal_flat       (pal_flat),
        .pal_set        (pal_set),
        .pal_idx        (pal_idx),
        .blink          (blink),
        .blink_freeze   (blink_freeze)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic io_wr(input logic [14:0] a, input logic [7:0] d);
        bus.bus_a     = a;
        bus.bus_d     = d;
        bus.bus_iow_l = 1'b0;
        repeat (4) @(negedge clk);
        bus.bus_iow_l = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: observed no finish, expected finish before 300000");
        $fatal(1);
    end

    initial begin
        logic pulse, found;
        logic prev;
        int   n;

        reset = 1'b1;
        bus.bus_a = 15'h0000;  bus.bus_d = 8'h00;
        bus.bus_ior_l = 1'b1;  bus.bus_iow_l = 1'b1;
        bus.bus_memr_l = 1'b1; bus.bus_memw_l = 1'b1;
        bus.bus_aen = 1'b0;    bus.bus_mem_cs = 1'b0;
        clk_seq = 5'd0; vsync_l = 1'b1; display_enable = 1'b0;
        crtc_rdata = 8'h00; blink_freeze = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_control", 32'(control_reg), 32'h29);
        chk("rst_color", 32'(color_reg), 32'h00);
        chk("rst_border", 32'(border_col), 32'h0);
        chk("rst_pal_flat", 32'(pal_flat), 32'h0000);
        chk("rst_pal_set", 32'(pal_set), 32'h0);
        chk("rst_pal_idx", 32'(pal_idx), 32'h0);
        chk("rst_blink", 32'(blink), 32'h0);
        chk("rst_bus_rdy", 32'(bus.bus_rdy), 32'h1);
        chk("rst_crtc_wr", 32'(crtc_wr), 32'h0);
        chk("rst_crtc_rd", 32'(crtc_rd), 32'h0);
        reset = 1'b0;

        // Control write: update lands on the third clock after the iow fall.
        bus.bus_a = 15'h03D8; bus.bus_d = 8'h1A; bus.bus_iow_l = 1'b0;
        @(negedge clk);
        chk("ctrl_wr_c1_crtc_wr", 32'(crtc_wr), 32'h0);
        chk("ctrl_wr_c1", 32'(control_reg), 32'h29);
        @(negedge clk);
        chk("ctrl_wr_c2_crtc_wr", 32'(crtc_wr), 32'h1);
        chk("ctrl_wr_c2", 32'(control_reg), 32'h29);
        @(negedge clk);
        chk("ctrl_wr_c3", 32'(control_reg), 32'h1A);
        bus.bus_d = 8'h77;
        repeat (17) @(negedge clk);
        chk("ctrl_long_hold_single", 32'(control_reg), 32'h1A);
        bus.bus_iow_l = 1'b1;
        repeat (3) @(negedge clk);
        chk("crtc_wr_release", 32'(crtc_wr), 32'h0);

        // Palette entry 3.
        io_wr(15'h03DA, 8'h13);
        bus.bus_a = 15'h03DE; bus.bus_d = 8'h07; bus.bus_iow_l = 1'b0;
        repeat (2) @(negedge clk);
        chk("pal_set_early", 32'(pal_set), 32'h0);
        @(negedge clk);
        chk("pal_set_pulse", 32'(pal_set), 32'h1);
        chk("pal_idx_3", 32'(pal_idx), 32'h3);
        chk("pal_entry3", 32'(pal_flat), 32'h7000);
        @(negedge clk);
        chk("pal_set_one_cycle", 32'(pal_set), 32'h0);
        bus.bus_iow_l = 1'b1;
        repeat (3) @(negedge clk);

        // Index 0x14 is beyond a 4-entry palette.
        io_wr(15'h03DA, 8'h14);
        bus.bus_a = 15'h03DE; bus.bus_d = 8'h09; bus.bus_iow_l = 1'b0;
        pulse = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pulse = pulse | pal_set;
        end
        bus.bus_iow_l = 1'b1;
        repeat (3) @(negedge clk);
        chk("pal_oob_no_pulse", 32'(pulse), 32'h0);
        chk("pal_oob_flat", 32'(pal_flat), 32'h7000);
        chk("pal_oob_idx", 32'(pal_idx), 32'h3);

        // Border color through Tandy index 2.
        io_wr(15'h03DA, 8'h02);
        io_wr(15'h03DE, 8'h0C);
        chk("border_c", 32'(border_col), 32'hC);
        chk("border_pal_kept", 32'(pal_flat), 32'h7000);

        io_wr(15'h03D9, 8'hA5);
        chk("color_a5", 32'(color_reg), 32'hA5);

        bus.bus_aen = 1'b1;
        io_wr(15'h03D8, 8'hFF);
        bus.bus_aen = 1'b0;
        chk("aen_blocks_write", 32'(control_reg), 32'h1A);

        // Reads.
        bus.bus_a = 15'h03DA; vsync_l = 1'b0; display_enable = 1'b1;
        bus.bus_ior_l = 1'b0;
        #2;
        chk("rd_status", 32'(bus.bus_out), 32'hF4);
        chk("rd_status_dir", 32'(bus.bus_dir), 32'h1);
        bus.bus_a = 15'h03D5; crtc_rdata = 8'h55;
        #2;
        chk("rd_crtc_data", 32'(bus.bus_out), 32'h55);
        chk("rd_crtc_cs", 32'(crtc_cs), 32'h1);
        bus.bus_a = 15'h03D4;
        #2;
        chk("rd_crtc_index", 32'(bus.bus_out), 32'h00);
        chk("rd_crtc_index_dir", 32'(bus.bus_dir), 32'h1);
        bus.bus_aen = 1'b1;
        #2;
        chk("rd_aen_dir", 32'(bus.bus_dir), 32'h0);
        bus.bus_ior_l = 1'b1; bus.bus_aen = 1'b0;
        repeat (3) @(negedge clk);

        // Full wait: ready low from req+1 until the cycle after seq 20 follows 17.
        clk_seq = 5'd0; bus.bus_mem_cs = 1'b1; bus.bus_memr_l = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            chk($sformatf("wait_rdy_k%0d", k), 32'(bus.bus_rdy),
                (k >= 3 && k <= 20) ? 32'h0 : 32'h1);
            clk_seq = clk_seq + 5'd1;
        end
        bus.bus_memr_l = 1'b1;
        repeat (4) @(negedge clk);

        // Request dropped mid-wait.
        clk_seq = 5'd0; bus.bus_memr_l = 1'b0;
        repeat (4) @(negedge clk);
        chk("drop_waiting", 32'(bus.bus_rdy), 32'h0);
        bus.bus_memr_l = 1'b1;
        @(negedge clk);
        chk("drop_sync1", 32'(bus.bus_rdy), 32'h0);
        @(negedge clk);
        chk("drop_sync2", 32'(bus.bus_rdy), 32'h0);
        @(negedge clk);
        chk("drop_released", 32'(bus.bus_rdy), 32'h1);
        repeat (2) @(negedge clk);

        // Reset while in WAIT_END, then confirm the FSM restarts from IDLE.
        clk_seq = 5'd17; bus.bus_memr_l = 1'b0;
        repeat (4) @(negedge clk);
        chk("wait_end_low", 32'(bus.bus_rdy), 32'h0);
        clk_seq = 5'd0; reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_wait_rdy", 32'(bus.bus_rdy), 32'h1);
        chk("reset_mid_ctrl", 32'(control_reg), 32'h29);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_rdy1", 32'(bus.bus_rdy), 32'h1);
        @(negedge clk);
        chk("post_reset_rdy2", 32'(bus.bus_rdy), 32'h1);
        @(negedge clk);
        chk("post_reset_slot", 32'(bus.bus_rdy), 32'h0);
        bus.bus_memr_l = 1'b1; bus.bus_mem_cs = 1'b0;
        repeat (4) @(negedge clk);

        // Blink period and freeze.
        prev = blink; found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (blink !== prev) found = 1'b1;
        end
        chk("blink_toggles", 32'(found), 32'h1);
        prev = blink; n = 0; found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            n++;
            if (blink !== prev) found = 1'b1;
        end
        chk("blink_period", 32'(n), 32'd4);
        blink_freeze = 1'b1; prev = blink; pulse = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (blink !== prev) pulse = 1'b1;
        end
        chk("blink_frozen", 32'(pulse), 32'h0);
        blink_freeze = 1'b0; n = 0; found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            n++;
            if (blink !== prev) found = 1'b1;
        end
        chk("blink_resume", 32'(n), 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
